// File: rtl/rst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rst_sequencer                                              |
// | Description : Reset controller for the DUT-side reset tree. Synchronises |
// |               the deassertion of arstn, then releases N_OUT synchronous  |
// |               active-low domain resets in ascending order after a hold   |
// |               delay, with a fixed step between releases. A software      |
// |               request (req/ack) re-runs the whole sequence.              |
// |               Optional watchdog: define RST_SEQ_WDOG_EN.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rst_sequencer #(
    parameter int N_OUT       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int STEP_CYCLES = 4,
    parameter int WDOG_CYCLES = 256
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             sw_rst_req,
    output logic             sw_rst_ack,
    output logic [N_OUT-1:0] srstn_o,
    output logic             busy,
    output logic             done
`ifdef RST_SEQ_WDOG_EN
    ,
    input  logic             wdog_kick,
    output logic             wdog_flag
`endif
);

    localparam int c_max_hs  = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int c_max_all = (c_max_hs > WDOG_CYCLES) ? c_max_hs : WDOG_CYCLES;
    localparam int c_cnt_w   = $clog2(c_max_all + 1);
    localparam int c_idx_w   = $clog2(N_OUT + 1);

    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_step_last = c_cnt_w'(STEP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(N_OUT - 1);
    localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);

    localparam logic [1:0] c_st_assert  = 2'd0;
    localparam logic [1:0] c_st_release = 2'd1;
    localparam logic [1:0] c_st_run     = 2'd2;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req;
    logic                   r_req_q;
    logic [1:0]             r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_idx_w-1:0]     r_idx;
    logic [N_OUT-1:0]       r_srstn;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ack;
    logic                   r_pend;

    logic                   w_synced;
    logic                   w_sw_trig;
    logic                   w_wdog_trig;
    logic                   w_trig;
    logic [N_OUT-1:0]       w_rel_mask;

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_sw_trig = r_req & ~r_req_q;
    assign w_trig    = w_sw_trig | w_wdog_trig;

    // Deassertion synchroniser: shifts ones in after arstn goes high
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Request register and rising-edge detector; a held level does not retrigger
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_req   <= 1'b0;
            r_req_q <= 1'b0;
        end else begin
            r_req   <= sw_rst_req;
            r_req_q <= r_req;
        end
    end

    // One-hot select of the domain reset released at the current step
    always_comb begin
        w_rel_mask = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_rel_mask[i] = 1'b1;
            end
        end
    end

    // Sequencing FSM: hold, stepped release, run; any trigger restarts from ASSERT
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= c_st_assert;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_srstn <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_ack   <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_trig) begin
                // A trigger wins over a coincident final release: no done, no ack
                r_state <= c_st_assert;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_srstn <= '0;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_pend  <= w_sw_trig;
            end else begin
                case (r_state)
                    c_st_assert: begin
                        // Counter stays at 0 until the synchroniser reports arstn high
                        if (w_synced) begin
                            if (r_cnt == c_hold_last) begin
                                r_state <= c_st_release;
                                r_cnt   <= '0;
                                r_idx   <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_cnt_one;
                            end
                        end
                    end
                    c_st_release: begin
                        if (r_cnt == c_step_last) begin
                            r_cnt   <= '0;
                            r_srstn <= r_srstn | w_rel_mask;
                            r_idx   <= r_idx + c_idx_one;
                            if (r_idx == c_idx_last) begin
                                r_state <= c_st_run;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_ack   <= r_pend;
                                r_pend  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                    c_st_run: begin
                        r_srstn <= '1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    default: begin
                        r_state <= c_st_assert;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_srstn <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam logic [c_cnt_w-1:0] c_wdog_last = c_cnt_w'(WDOG_CYCLES - 1);

    logic [c_cnt_w-1:0] r_wdog_cnt;
    logic               r_wdog_flag;

    assign w_wdog_trig = (r_state == c_st_run) && !wdog_kick && (r_wdog_cnt == c_wdog_last);
    assign wdog_flag   = r_wdog_flag;

    // Watchdog: counts only in RUN, cleared by a kick; flag is sticky until arstn
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_wdog_cnt  <= '0;
            r_wdog_flag <= 1'b0;
        end else begin
            if (w_wdog_trig) begin
                r_wdog_flag <= 1'b1;
            end
            if ((r_state != c_st_run) || w_trig || wdog_kick) begin
                r_wdog_cnt <= '0;
            end else begin
                r_wdog_cnt <= r_wdog_cnt + c_cnt_one;
            end
        end
    end
`else
    assign w_wdog_trig = 1'b0;
`endif

    assign srstn_o    = r_srstn;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sw_rst_ack = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rst_sequencer                                           |
// | Description : Self-checking bench for rst_sequencer. A main instance     |
// |               (N_OUT=4, SYNC=2, HOLD=8, STEP=4, WDOG=16) and a corner    |
// |               instance (N_OUT=1, HOLD=1, STEP=1). Watchdog scenario is   |
// |               built when RST_SEQ_WDOG_EN is defined.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rst_sequencer;

    localparam int N_OUT = 4;
    localparam int SYNC  = 2;
    localparam int HOLD  = 8;
    localparam int STEP  = 4;
    localparam int WDOG  = 16;

    logic             clk = 1'b0;
    logic             arstn = 1'b1;
    logic             sw_rst_req = 1'b0;
    logic             sw_rst_ack;
    logic [N_OUT-1:0] srstn_o;
    logic             busy;
    logic             done;

    logic             arstn_c = 1'b1;
    logic             req_c = 1'b0;
    logic             ack_c;
    logic [0:0]       srstn_c;
    logic             busy_c;
    logic             done_c;

`ifdef RST_SEQ_WDOG_EN
    logic             wdog_kick = 1'b1;
    logic             wdog_flag;
    logic             kick_c = 1'b1;
    logic             flag_c;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [15:0] sb_q[$];

    rst_sequencer #(
        .N_OUT(N_OUT), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD),
        .STEP_CYCLES(STEP), .WDOG_CYCLES(WDOG)
    ) u_dut (
        .clk(clk), .arstn(arstn), .sw_rst_req(sw_rst_req), .sw_rst_ack(sw_rst_ack),
        .srstn_o(srstn_o), .busy(busy), .done(done)
`ifdef RST_SEQ_WDOG_EN
        , .wdog_kick(wdog_kick), .wdog_flag(wdog_flag)
`endif
    );

    rst_sequencer #(
        .N_OUT(1), .SYNC_STAGES(2), .HOLD_CYCLES(1),
        .STEP_CYCLES(1), .WDOG_CYCLES(WDOG)
    ) u_dut_c (
        .clk(clk), .arstn(arstn_c), .sw_rst_req(req_c), .sw_rst_ack(ack_c),
        .srstn_o(srstn_c), .busy(busy_c), .done(done_c)
`ifdef RST_SEQ_WDOG_EN
        , .wdog_kick(kick_c), .wdog_flag(flag_c)
`endif
    );

    always #5 clk = ~clk;

    // Expected {srstn[n-1:0], done, busy, ack} at edge t after the sequence origin.
    // t<=0 means the sequence has not started yet (block still in RUN).
    function automatic logic [15:0] exp_vec(input int t, input int base, input bit sw,
                                            input int n, input int step);
        logic [15:0] v;
        bit d;
        v = '0;
        if (t <= 0) begin
            for (int i = 0; i < n; i++) v[i+3] = 1'b1;
            v[2] = 1'b1;
            return v;
        end
        for (int i = 0; i < n; i++) v[i+3] = (t >= base + (i + 1) * step);
        d    = (t >= base + n * step);
        v[2] = d;
        v[1] = !d;
        v[0] = sw && (t == base + n * step);
        return v;
    endfunction

    function automatic logic [15:0] obs_main();
        return 16'({srstn_o, done, busy, sw_rst_ack});
    endfunction

    function automatic logic [15:0] obs_corner();
        return 16'({srstn_c, done_c, busy_c, ack_c});
    endfunction

    task automatic test_reset();
        logic [15:0] o, e;
        #2 arstn = 1'b0; arstn_c = 1'b0;
        #1;
        o = obs_main(); e = 16'b0000_0_1_0;
        n_assert++;
        if (o !== e) begin
            n_fail++; $display("FAIL reset_main: got %b expected %b", o, e);
        end
        o = obs_corner(); e = 16'b0_0_1_0;
        n_assert++;
        if (o !== e) begin
            n_fail++; $display("FAIL reset_corner: got %b expected %b", o, e);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_powerup();
        logic [15:0] o, e;
        arstn = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            sb_q.push_back(exp_vec(c, SYNC + HOLD, 1'b0, N_OUT, STEP));
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = obs_main();
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("FAIL powerup edge %0d: got %b expected %b", c, o, e);
            end
        end
    endtask

    task automatic test_async_abort();
        logic [15:0] o, e;
        arstn = 1'b0;
        @(posedge clk); #1;
        arstn = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            sb_q.push_back(exp_vec(c, SYNC + HOLD, 1'b0, N_OUT, STEP));
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = obs_main();
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("FAIL abort_pre edge %0d: got %b expected %b", c, o, e);
            end
        end
        #2 arstn = 1'b0;
        #1;
        o = obs_main(); e = 16'b0000_0_1_0;
        n_assert++;
        if (o !== e) begin
            n_fail++; $display("FAIL abort_async: got %b expected %b", o, e);
        end
        @(posedge clk); #1;
        arstn = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            sb_q.push_back(exp_vec(c, SYNC + HOLD, 1'b0, N_OUT, STEP));
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = obs_main();
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("FAIL abort_restart edge %0d: got %b expected %b", c, o, e);
            end
        end
    endtask

    task automatic test_sw_request();
        logic [15:0] o, e;
        sw_rst_req = 1'b1;
        for (int c = 0; c <= 60; c++) begin
            sb_q.push_back(exp_vec(c, 1 + HOLD, 1'b1, N_OUT, STEP));
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = obs_main();
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("FAIL sw_req k+%0d: got %b expected %b", c, o, e);
            end
        end
        sw_rst_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] o, e;
        int acks = 0;
        for (int c = 0; c <= 50; c++) begin
            sw_rst_req = (c < 2) || (c >= 15);
            sb_q.push_back((c <= 15) ? exp_vec(c, 1 + HOLD, 1'b1, N_OUT, STEP)
                                     : exp_vec(c - 15, 1 + HOLD, 1'b1, N_OUT, STEP));
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = obs_main();
            acks += int'(sw_rst_ack);
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("FAIL back_to_back k+%0d: got %b expected %b", c, o, e);
            end
        end
        n_assert++;
        if (acks !== 1) begin
            n_fail++; $display("FAIL back_to_back_ack_count: got %0d expected 1", acks);
        end
        sw_rst_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_collision();
        logic [15:0] o, e;
        for (int c = 0; c <= 55; c++) begin
            sw_rst_req = (c < 2) || (c >= 24);
            sb_q.push_back((c <= 24) ? exp_vec(c, 1 + HOLD, 1'b1, N_OUT, STEP)
                                     : exp_vec(c - 24, 1 + HOLD, 1'b1, N_OUT, STEP));
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = obs_main();
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("FAIL collision k+%0d: got %b expected %b", c, o, e);
            end
        end
        sw_rst_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_corner();
        logic [15:0] o, e;
        arstn_c = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            sb_q.push_back(exp_vec(c, 2 + 1, 1'b0, 1, 1));
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = obs_corner();
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("FAIL corner_powerup edge %0d: got %b expected %b", c, o, e);
            end
        end
        req_c = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            sb_q.push_back(exp_vec(c, 1 + 1, 1'b1, 1, 1));
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = obs_corner();
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("FAIL corner_sw k+%0d: got %b expected %b", c, o, e);
            end
        end
        req_c = 1'b0;
    endtask

`ifdef RST_SEQ_WDOG_EN
    task automatic test_watchdog();
        logic [15:0] o, e;
        logic f;
        for (int c = 0; c <= 100; c++) begin
            wdog_kick = ((c <= 50) && (c % 10 == 0)) || (c >= 91);
            sb_q.push_back(exp_vec(c - 65, 1 + HOLD, 1'b0, N_OUT, STEP));
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = obs_main();
            n_assert++;
            if (o !== e) begin
                n_fail++; $display("FAIL wdog_seq c%0d: got %b expected %b", c, o, e);
            end
            f = (c >= 66);
            n_assert++;
            if (wdog_flag !== f) begin
                n_fail++; $display("FAIL wdog_flag c%0d: got %b expected %b", c, wdog_flag, f);
            end
        end
        #2 arstn = 1'b0;
        #1;
        n_assert++;
        if (wdog_flag !== 1'b0) begin
            n_fail++; $display("FAIL wdog_flag_clear: got %b expected 0", wdog_flag);
        end
        @(posedge clk); #1;
        arstn = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_powerup();
        test_async_abort();
        test_sw_request();
        test_back_to_back();
        test_collision();
        test_corner();
`ifdef RST_SEQ_WDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
